// File: rtl/mult_rr_scheduler.sv
// Round-robin front end for one shared sequential signed multiplier.
// Accepts one operand pair at a time from NREQ requesters, launches the
// multiplier, captures its product and returns it tagged with the owner ID.
module mult_rr_scheduler #(
    parameter int N     = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ),
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*N-1:0]    req_a,
    input  logic [NREQ*N-1:0]    req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [2*N-1:0]       resp_c,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count,
    output logic                 mult_load,
    output logic [N-1:0]         mult_a,
    output logic [N-1:0]         mult_b,
    input  logic                 mult_done,
    input  logic [2*N-1:0]       mult_c
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // NREQ always fits in IDW+1 bits, which keeps the modulo wrap exact
    // for non-power-of-two requester counts.
    localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] cur_id;
    logic [IDW-1:0] win_id;
    logic           win_vld;
    logic [IDW:0]   arb_sum;
    logic [IDW-1:0] arb_idx;
    logic           accept;

    assign accept = (state == IDLE) && win_vld;

    // Rotating priority search: first valid requester at or after rr_ptr.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        arb_sum = '0;
        arb_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            arb_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (arb_sum >= NREQ_W)
                arb_sum = arb_sum - NREQ_W;
            arb_idx = arb_sum[IDW-1:0];
            if (!win_vld && req_valid[arb_idx]) begin
                win_vld = 1'b1;
                win_id  = arb_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; a single operation is in flight until its response is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld)    state_nxt = ISSUE;
            ISSUE:                   state_nxt = WAIT;
            WAIT:    if (mult_done)  state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Combinational outputs: grant only the arbitration winner, and only while idle.
    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[win_id] = 1'b1;
        busy = (state != IDLE);
    end

    // Datapath: operand latch, load pulse, product capture, pointer and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_load  <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            cur_id     <= '0;
            rr_ptr     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_c     <= '0;
            op_count   <= '0;
        end else begin
            // High exactly during the single ISSUE cycle.
            mult_load <= accept;
            if (accept) begin
                mult_a <= req_a[win_id*N +: N];
                mult_b <= req_b[win_id*N +: N];
                cur_id <= win_id;
            end
            // Done pulses outside WAIT belong to nobody and are dropped.
            if (state == WAIT && mult_done) begin
                resp_c     <= mult_c;
                resp_id    <= cur_id;
                resp_valid <= 1'b1;
            end
            if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
                rr_ptr     <= (cur_id == LAST_ID) ? '0 : cur_id + IDW'(1);
                if (op_count != {CNT_W{1'b1}})
                    op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Round-robin scheduler that shares one sequential signed multiplier among NREQ requesters.
- Each requester gets a valid/ready operand port. The block drives the multiplier's load/A/B and captures its product on done, then returns the product with the requester ID over a valid/ready response port.
- Sits between client blocks and a single multiplier instance that uses the same clk/rst_n. One operation is outstanding at a time.

Parameters:
- N, 32, operand width; product width is 2N.
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), width of the requester ID.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  NREQ*N  packed multiplicands; slice i is [i*N +: N], signed.
- req_b  input  NREQ*N  packed multipliers; slice i is [i*N +: N], signed.
- resp_valid  output  1  product available.
- resp_ready  input  1  consumer accepts product.
- resp_id  output  IDW  index of the requester that owns resp_c.
- resp_c  output  2N  signed product.
- busy  output  1  high in every state except IDLE.
- op_count  output  CNT_W  completed operations; saturating.
- mult_load  output  1  start pulse to the multiplier.
- mult_a  output  N  multiplicand to the multiplier.
- mult_b  output  N  multiplier operand to the multiplier.
- mult_done  input  1  one-cycle completion pulse from the multiplier.
- mult_c  input  2N  product from the multiplier; valid when mult_done=1.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, rr_ptr=0.
  - All registered outputs are 0: mult_load, mult_a, mult_b, resp_valid, resp_id, resp_c, op_count.
  - req_ready=0 and busy=0.
  - The multiplier shares rst_n, so a reset mid-operation aborts both blocks cleanly. No partial result is ever returned.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[winner]=1 is combinational, only in IDLE, only for the winner. The handshake completes in the same cycle.
  - On handshake: latch the winner's req_a/req_b slices into mult_a/mult_b, latch the winner index into cur_id, go to ISSUE.
  - With no req_valid set, stay in IDLE.
- ISSUE:
  - mult_load=1 for exactly this one cycle, then go to WAIT.
  - mult_a/mult_b are held constant from handshake until the next handshake. The multiplier samples its operands after load.
- WAIT:
  - mult_load=0.
  - On mult_done=1: register mult_c into resp_c, set resp_id=cur_id, set resp_valid=1, go to RESP.
  - There is no timeout; the block waits indefinitely.
- RESP:
  - resp_valid, resp_c and resp_id stay stable until resp_ready=1.
  - On resp_valid&&resp_ready:
    - Clear resp_valid.
    - rr_ptr = (cur_id+1) mod NREQ.
    - op_count += 1, saturating at all-ones.
    - Go to IDLE.
  - resp_c and resp_id keep their last values after the response is consumed.
  - resp_ready may already be high in the cycle resp_valid rises. The transfer then completes in that cycle.
- mult_done is ignored in IDLE, ISSUE and RESP.
- A requester dropping req_valid while not granted is legal and has no effect.
- No new request is accepted until the current response has been consumed (single outstanding operation).
- Controller overhead:
  - load is asserted 1 cycle after accept.
  - resp_valid is asserted 1 cycle after mult_done.
  - Earliest next accept is the cycle after the response handshake.
- Fairness: a requester that holds req_valid is granted within NREQ operations.
- Arithmetic: the block does no arithmetic on operands; it passes them through. Only op_count and rr_ptr perform increments.

Test Plan:
1. Single op: N=32; req0 sends A=7, B=-3; resp_ready=1 → exactly one mult_load pulse; resp_c=0xFFFFFFFF_FFFFFFEB (-21); resp_id=0; op_count=1.
2. Round-robin: all four req_valid held high, with A=i+1 and B=10 on port i → grant order 0,1,2,3,0; products 10,20,30,40,10; req_ready always one-hot.
3. Pointer skip: after a grant to 0, only req2 and req3 valid → grant 2 then 3; next grant is 0 when all are valid.
4. Backpressure: hold resp_ready=0 for 10 cycles after resp_valid (A=-5, B=-6) → resp_valid stays 1; resp_c=30 stays stable; req_ready=0 throughout; completes on the first cycle resp_ready=1.
5. Reset mid-WAIT: pulse rst_n low during WAIT → all outputs 0 immediately; no resp_valid afterwards; the next request is served from rr_ptr=0.
6. Saturation: CNT_W=2, run 5 ops → op_count = 1,2,3,3,3.
